spi_prot_trig: RTL and testbench
================================

// Module: spi_prot_trig
// PURPOSE
//  SPI protocol trigger unit inside LA_dig. Watches CH1/CH2/CH3 (SS_n/SCLK/MOSI),
//  captures each SPI frame, and pulses SPItrig when the frame matches a masked
//  8- or 16-bit pattern. Output feeds the LA trigger logic; inputs are raw,
//  asynchronous channel levels from the AFE comparators.
// PARAMETERS
//  SYNC_STG  2  metastability flops per input ahead of the edge-detect flop (2 or 3)
// PORTS
//  clk      in   1   system clock (100 MHz)
//  rst      in   1   asynchronous reset, active-high
//  SS_n     in   1   raw SPI slave select (async, active low)
//  SCLK     in   1   raw SPI clock (async)
//  MOSI     in   1   raw SPI data (async)
//  trig_en  in   1   1 = triggering armed; 0 = SPItrig held low
//  edg      in   1   1 = sample MOSI on SCLK rise, 0 = on SCLK fall
//  len8     in   1   1 = 8-bit frame compare, 0 = 16-bit
//  match    in   16  pattern; bits [7:0] only used when len8=1
//  mask     in   16  1 = don't-care bit
//  busy     out  1   1 while a frame is being received (state RX)
//  SPItrig  out  1   one-clk pulse on matching frame end
// BEHAVIOUR
//  Reset (async, rst=1): all sync flops to idle levels (SS_n=1, SCLK=1, MOSI=0),
//   shft=0, bit_cnt=0, state=IDLE, busy=0, SPItrig=0.
//  Sync: each input through SYNC_STG flops, then one more flop (_ff) for edge detect.
//   ss_fall = ~ss_s & ss_ff; ss_rise = ss_s & ~ss_ff;
//   sclk_edge = edg ? (sclk_s & ~sclk_ff) : (~sclk_s & sclk_ff).
//  State machine (IDLE, RX):
//   IDLE: on ss_fall -> RX; shft<=0, bit_cnt<=0. SCLK edges ignored in IDLE.
//   RX: on sclk_edge: shft <= {shft[14:0], mosi_s} (MSB first);
//       bit_cnt <= bit_cnt+1, saturating at 31 (5-bit).
//     on ss_rise -> IDLE and evaluate frame (same cycle); an sclk_edge in that
//       same cycle is NOT shifted (SS_n deassert wins).
//  Match: len8=1: hit = bit_cnt==8  && ((shft[7:0]^match[7:0]) & ~mask[7:0])==0
//         len8=0: hit = bit_cnt==16 && ((shft^match) & ~mask)==0
//   Frames of any other length never trigger (short/long frame rejected).
//  SPItrig: registered; = hit & trig_en, high exactly one clk in cycle after
//   ss_rise is detected. Latency raw SS_n rise -> SPItrig = SYNC_STG+2 clk edges.
//  busy = (state==RX), registered from state.
//  edg/len8/match/mask/trig_en sampled live; must be stable during a frame.
//  Back-to-back frames: ss_fall in cycle after ss_rise starts new frame normally.
//  SCLK glitch narrower than 1 clk may be missed; SCLK must be <= clk/4.
//  rst mid-frame: abort, return to IDLE, no SPItrig for the partial frame.
// TESTING
//  1 SPI_mstr width8, data 16'h6600, match=16'h0066, mask=0, len8=1, trig_en=1
//    -> exactly one SPItrig pulse, SYNC_STG+2 clk after SS_n rises; busy low after.
//  2 Same frame, match=16'h0067, mask=0 -> no SPItrig; mask=16'h0001 -> one pulse.
//  3 16-bit frame 16'hA5C3, len8=0, match=16'hA5C3 -> one pulse; match=16'hA5C2 -> none;
//    same frame with len8=1, match=16'h00C3 -> none (bit_cnt=16 != 8).
//  4 Frame of 7 SCLK edges, len8=1, pattern matching -> no SPItrig; 9-edge frame -> none.
//  5 Assert rst after 4 bits of 0x66 frame, release, send full 0x66 frame
//    -> busy=0 and SPItrig=0 during/after reset; single pulse for second frame only.
//  6 trig_en=0 with matching frame -> SPItrig stays 0; busy still toggles; both edg values
//    checked against frame driven on matching SCLK edge.

Source files
------------

// File: rtl/spi_prot_trig.sv
// SPI protocol trigger: synchronizes SS_n/SCLK/MOSI, captures each SPI frame
// MSB first and pulses SPItrig for one clock when a complete frame matches a masked 8- or 16-bit pattern.
module spi_prot_trig #(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        trig_en,
  input  logic        edg,
  input  logic        len8,
  input  logic [15:0] match,
  input  logic [15:0] mask,
  output logic        busy,
  output logic        SPItrig
);

  typedef enum logic {IDLE, RX} state_t;

  state_t              state;
  logic [SYNC_STG-1:0] ss_sync;
  logic [SYNC_STG-1:0] sclk_sync;
  logic [SYNC_STG-1:0] mosi_sync;
  logic                ss_ff;
  logic                sclk_ff;
  logic                ss_s;
  logic                sclk_s;
  logic                mosi_s;
  logic                ss_fall;
  logic                ss_rise;
  logic                sclk_edge;
  logic [15:0]         shft;
  logic [4:0]          bit_cnt;
  logic                hit;

  // Synchronizers reset to bus-idle levels so reset release creates no edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      ss_ff     <= 1'b1;
      sclk_ff   <= 1'b1;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STG-2:0], SS_n};
      sclk_sync <= {sclk_sync[SYNC_STG-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], MOSI};
      ss_ff     <= ss_sync[SYNC_STG-1];
      sclk_ff   <= sclk_sync[SYNC_STG-1];
    end
  end

  assign ss_s      = ss_sync[SYNC_STG-1];
  assign sclk_s    = sclk_sync[SYNC_STG-1];
  assign mosi_s    = mosi_sync[SYNC_STG-1];
  assign ss_fall   = ~ss_s & ss_ff;
  assign ss_rise   = ss_s & ~ss_ff;
  assign sclk_edge = edg ? (sclk_s & ~sclk_ff) : (~sclk_s & sclk_ff);

  always_comb begin
    hit = 1'b0;
    if (len8)
      hit = (bit_cnt == 5'd8) && (((shft[7:0] ^ match[7:0]) & ~mask[7:0]) == '0);
    else
      hit = (bit_cnt == 5'd16) && (((shft ^ match) & ~mask) == '0);
  end

  // An SCLK edge coincident with SS_n deassert is dropped: frame end takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shft    <= '0;
      bit_cnt <= '0;
      busy    <= 1'b0;
      SPItrig <= 1'b0;
    end else begin
      SPItrig <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            state   <= RX;
            busy    <= 1'b1;
            shft    <= '0;
            bit_cnt <= '0;
          end
        end
        RX: begin
          if (ss_rise) begin
            state   <= IDLE;
            busy    <= 1'b0;
            SPItrig <= hit & trig_en;
          end else if (sclk_edge) begin
            shft <= {shft[14:0], mosi_s};
            if (bit_cnt != 5'd31)
              bit_cnt <= bit_cnt + 5'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_prot_trig.sv
// Bench for spi_prot_trig: drives SPI frames and compares trigger pulses,
// latency and busy against a frame-level reference model.
module tb_spi_prot_trig;

  localparam int unsigned SYNC_STG = 2;
  localparam int          LAT      = SYNC_STG + 2;

  typedef struct {
    logic [15:0] data;
    int          n;
    logic        l8;
    logic [15:0] m;
    logic [15:0] k;
    logic        en;
    logic        e;
  } frame_t;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        SS_n    = 1'b1;
  logic        SCLK    = 1'b1;
  logic        MOSI    = 1'b0;
  logic        trig_en = 1'b0;
  logic        edg     = 1'b1;
  logic        len8    = 1'b1;
  logic [15:0] match   = '0;
  logic [15:0] mask    = '0;
  logic        busy;
  logic        SPItrig;

  int          total = 0;
  int          bad   = 0;
  int unsigned edge_cnt  = 0;
  int unsigned rise_edge = 0;
  int          lats[$];

  spi_prot_trig #(.SYNC_STG(SYNC_STG)) dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .trig_en (trig_en),
    .edg     (edg),
    .len8    (len8),
    .match   (match),
    .mask    (mask),
    .busy    (busy),
    .SPItrig (SPItrig)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  // Latency counts clock edges from the one at which SS_n was raised, inclusive.
  always @(negedge clk) if (SPItrig === 1'b1) lats.push_back(int'(edge_cnt - rise_edge) + 1);

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Frame-level reference: the received value is the first n bits sent, MSB first.
  function automatic bit model_hit(input logic [15:0] data, input int n, input logic l8,
                                   input logic [15:0] m, input logic [15:0] k, input logic en);
    logic [15:0] recv;
    logic [15:0] diff;
    recv = data >> (16 - n);
    diff = (recv ^ m) & ~k;
    if (!en) return 1'b0;
    if (l8) return (n == 8) && (diff[7:0] == 8'h00);
    return (n == 16) && (diff == 16'h0000);
  endfunction

  task automatic send_bits(input logic [15:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      SCLK = edg ? 1'b0 : 1'b1;
      tick(4);
      MOSI = data[15-i];
      tick(4);
      SCLK = edg ? 1'b1 : 1'b0;
      tick(4);
    end
  endtask

  task automatic drive_frame(input logic [15:0] data, input int n, output logic busy_mid);
    SS_n = 1'b0;
    tick(6);
    busy_mid = busy;
    send_bits(data, n);
    SCLK = 1'b1;
    tick(6);
    SS_n = 1'b1;
    rise_edge = edge_cnt;
  endtask

  task automatic test_reset;
    tick(4);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (SPItrig !== 1'b0) begin bad++; $display("FAIL reset_trig: got %b want 0", SPItrig); end
    rst = 1'b0;
    tick(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b want 0", busy); end
    total++; if (lats.size() != 0) begin bad++; $display("FAIL release_trig: got %0d pulses want 0", lats.size()); end
  endtask

  task automatic test_directed;
    frame_t dir[13];
    string  names[13];
    logic   bm;
    bit     exp;
    dir = '{
      '{16'h6600,  8, 1'b1, 16'h0066, 16'h0000, 1'b1, 1'b1},
      '{16'h6600,  8, 1'b1, 16'h0067, 16'h0000, 1'b1, 1'b1},
      '{16'h6600,  8, 1'b1, 16'h0067, 16'h0001, 1'b1, 1'b1},
      '{16'hA5C3, 16, 1'b0, 16'hA5C3, 16'h0000, 1'b1, 1'b1},
      '{16'hA5C3, 16, 1'b0, 16'hA5C2, 16'h0000, 1'b1, 1'b1},
      '{16'hA5C3, 16, 1'b1, 16'h00C3, 16'h0000, 1'b1, 1'b1},
      '{16'hCC00,  7, 1'b1, 16'h0066, 16'h0000, 1'b1, 1'b1},
      '{16'h3300,  9, 1'b1, 16'h0066, 16'h0000, 1'b1, 1'b1},
      '{16'h4B86, 15, 1'b0, 16'h25C3, 16'h0000, 1'b1, 1'b1},
      '{16'h6600,  8, 1'b1, 16'h0066, 16'h0000, 1'b0, 1'b1},
      '{16'h6600,  8, 1'b1, 16'h0066, 16'h0000, 1'b0, 1'b0},
      '{16'h6600,  8, 1'b1, 16'h0066, 16'h0000, 1'b1, 1'b0},
      '{16'hA5C3, 16, 1'b0, 16'hA5C3, 16'h0000, 1'b1, 1'b0}
    };
    names = '{"b8_hit", "b8_miss", "b8_mask", "b16_hit", "b16_miss", "b16_as8",
              "short7", "long9", "short15", "en0_rise", "en0_fall", "fall8_hit", "fall16_hit"};
    for (int i = 0; i < 13; i++) begin
      len8 = dir[i].l8; match = dir[i].m; mask = dir[i].k; trig_en = dir[i].en; edg = dir[i].e;
      exp = model_hit(dir[i].data, dir[i].n, dir[i].l8, dir[i].m, dir[i].k, dir[i].en);
      lats.delete();
      drive_frame(dir[i].data, dir[i].n, bm);
      tick(12);
      total++;
      if (lats.size() != (exp ? 1 : 0)) begin
        bad++; $display("FAIL %s_pulses: got %0d want %0d", names[i], lats.size(), exp ? 1 : 0);
      end
      if (exp && lats.size() > 0) begin
        total++;
        if (lats[0] != LAT) begin bad++; $display("FAIL %s_latency: got %0d want %0d", names[i], lats[0], LAT); end
      end
      total++; if (bm !== 1'b1) begin bad++; $display("FAIL %s_busy_mid: got %b want 1", names[i], bm); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %b want 0", names[i], busy); end
    end
  endtask

  task automatic test_rst_midframe;
    logic bm;
    len8 = 1'b1; match = 16'h0066; mask = '0; trig_en = 1'b1; edg = 1'b1;
    lats.delete();
    SS_n = 1'b0;
    tick(6);
    send_bits(16'h6600, 4);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      total++; if (SPItrig !== 1'b0) begin bad++; $display("FAIL rstmid_trig: got %b want 0", SPItrig); end
    end
    SS_n = 1'b1;
    SCLK = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
    total++; if (lats.size() != 0) begin bad++; $display("FAIL rstmid_partial: got %0d pulses want 0", lats.size()); end
    drive_frame(16'h6600, 8, bm);
    tick(12);
    total++; if (lats.size() != 1) begin bad++; $display("FAIL rstmid_second: got %0d pulses want 1", lats.size()); end
    if (lats.size() > 0) begin
      total++; if (lats[0] != LAT) begin bad++; $display("FAIL rstmid_latency: got %0d want %0d", lats[0], LAT); end
    end
  endtask

  task automatic test_back_to_back;
    logic bm1;
    logic bm2;
    len8 = 1'b1; match = 16'h0066; mask = '0; trig_en = 1'b1; edg = 1'b1;
    lats.delete();
    drive_frame(16'h6600, 8, bm1);
    tick(1);
    drive_frame(16'h6600, 8, bm2);
    tick(12);
    total++; if (lats.size() != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", lats.size()); end
    for (int i = 0; i < lats.size(); i++) begin
      total++; if (lats[i] != LAT) begin bad++; $display("FAIL b2b_latency%0d: got %0d want %0d", i, lats[i], LAT); end
    end
    total++; if (bm2 !== 1'b1) begin bad++; $display("FAIL b2b_busy_mid: got %b want 1", bm2); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_random;
    int          ns[9];
    logic [15:0] data;
    logic [15:0] recv;
    int          n;
    logic        bm;
    bit          exp;
    ns = '{7, 8, 8, 8, 9, 15, 16, 16, 16};
    for (int i = 0; i < 40; i++) begin
      data    = 16'($urandom);
      n       = ns[$urandom_range(8, 0)];
      len8    = (n < 12) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
      mask    = 16'($urandom & $urandom & $urandom);
      recv    = data >> (16 - n);
      match   = ($urandom_range(2, 0) == 0) ? 16'($urandom) : (recv ^ (16'($urandom) & mask));
      trig_en = ($urandom_range(4, 0) != 0);
      edg     = 1'($urandom);
      exp     = model_hit(data, n, len8, match, mask, trig_en);
      lats.delete();
      drive_frame(data, n, bm);
      tick(12);
      total++;
      if (lats.size() != (exp ? 1 : 0)) begin
        bad++; $display("FAIL rand%0d_pulses: data=%h n=%0d got %0d want %0d", i, data, n, lats.size(), exp ? 1 : 0);
      end
      if (exp && lats.size() > 0) begin
        total++;
        if (lats[0] != LAT) begin bad++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lats[0], LAT); end
      end
      total++; if (bm !== 1'b1) begin bad++; $display("FAIL rand%0d_busy_mid: got %b want 1", i, bm); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand%0d_busy_end: got %b want 0", i, busy); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_rst_midframe;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
